m_pipe_ctrl: RTL and testbench
==============================

// Module: m_pipe_ctrl
// PURPOSE
//  Pipeline sequencer for the 4-slot RV32 core: F (r_pc), D (P1_*), E (P2_*), W (P3_*).
//  Owns all stage write-enables and bubble (NOP 32'h13) insertion.
//  Handles: taken-branch flush, variable-latency imem/dmem handshakes, debug halt/step,
//  dmem timeout fault. Provides cycle, instret and stall counters.
// PARAMETERS
//  CNT_W     32  width of the performance counters
//  MAX_WAIT  16  dmem wait cycles without ack before FAULT (>=1)
//  WAIT_W     5  wait-timer width; must satisfy 2**WAIT_W > MAX_WAIT
// PORTS
//  w_clk       in   1      clock, all state on posedge
//  w_rst       in   1      synchronous, active-high reset
//  w_imem_ack  in   1      fetch word at r_pc valid this cycle
//  w_e_mem     in   1      E-stage instruction is a load/store (decoded P2_ld|P2_s)
//  w_dmem_ack  in   1      dmem access completes this cycle
//  w_br_tkn    in   1      E-stage taken branch (P2_b & w_tkn)
//  w_halt_req  in   1      debug halt request, level
//  w_step      in   1      single-step pulse while halted
//  w_pc_we     out  1      load r_pc from w_pcin
//  w_p1_we     out  1      load P1 regs
//  w_p1_nop    out  1      with w_p1_we: load P1_ir=32'h13 instead of w_ir
//  w_p2_we     out  1      load P2 regs
//  w_p2_nop    out  1      with w_p2_we: load P2 as NOP (all ctl bits 0, rd=0)
//  w_p3_we     out  1      load P3 regs; gates RF write
//  w_dmem_req  out  1      dmem request, held until ack
//  w_halted    out  1      state==HALT
//  w_fault     out  1      state==FAULT (sticky)
//  w_cycle     out  CNT_W  cycles since reset
//  w_instret   out  CNT_W  instructions retired from W
//  w_stall     out  CNT_W  non-advancing cycles in RUN/MEMWAIT
// BEHAVIOUR
//  - State RUN, MEMWAIT, HALT, FAULT; valid bits v1,v2,v3 for D/E/W; wait timer; ret flag.
//  - While w_rst=1: all *_we/*_nop/dmem_req=0. Next cycle: RUN, v*=0, counters=0, timer=0.
//  - br = w_br_tkn & v2; mem = v2 & w_e_mem.
//  - Advance equations (adv=1): pc_we=w_imem_ack|br; p1_we=p2_we=p3_we=1;
//    p1_nop=!w_imem_ack|br; p2_nop=!v1|br; v1<=w_imem_ack&!br; v2<=v1&!br; v3<=v2.
//  - adv=0: every *_we=0, v* hold.
//  - w_dmem_req = mem in RUN, MEMWAIT and HALT-step cycles; 0 in FAULT.
//  - RUN: adv = !mem|w_dmem_ack. mem&!ack -> MEMWAIT, timer=1, ret=RUN.
//    If adv & w_halt_req -> HALT; that cycle still advances.
//  - MEMWAIT: ack -> adv=1, go to ret, timer=0. Else timer==MAX_WAIT -> FAULT; else timer+1.
//  - HALT: adv=0 unless w_step=1; then the step cycle behaves exactly as RUN.
//    mem&!ack on a step -> MEMWAIT, ret=HALT. Exit HALT to RUN when w_halt_req=0 & !w_step.
//  - FAULT: adv=0, w_fault=1; exited only by w_rst.
//  - Same-cycle priority: dmem freeze > branch flush > imem miss.
//    A branch while frozen is held until advance.
//  - Counters wrap mod 2**CNT_W:
//    cycle +1 every non-reset cycle; instret +1 when adv&v3;
//    stall +1 when state in {RUN,MEMWAIT} & !adv.
//  - Outputs are combinational from state+inputs; no added latency. Ack is taken in its own cycle.
// STRUCTURE
//  - pipe_ctrl_pkg: state enum (RUN,MEMWAIT,HALT,FAULT), NOP_INSN=32'h13.
//  - Sub-module m_wait_timer (clear/inc/expire at MAX_WAIT).
// TESTING
//  1 Reset, imem_ack=1, no mem/br: v3 first set cycle 3; instret=N-3 after N cycles, stall=0.
//  2 br_tkn with v2=1: that cycle pc_we=1, p1_nop=1, p2_nop=1; next 2 cycles instret holds.
//  3 mem with ack after 3 cycles: 3 cycles all we=0, dmem_req=1; stall+=3; advance on ack cycle.
//  4 mem, no ack, MAX_WAIT=4: FAULT entered after cycle 4; fault=1 held; w_rst restores RUN.
//  5 halt_req during run: halted next cycle, we=0. One w_step pulse gives exactly one advance.
//  6 step hitting mem w/o ack: MEMWAIT, then HALT (not RUN) after ack.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the RV32 pipeline sequencer.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        StRun,
        StMemWait,
        StHalt,
        StFault
    } pipe_state_e;

    localparam logic [31:0] NOP_INSN = 32'h13;

endpackage

// File: rtl/m_wait_timer.sv
// Counts dmem wait cycles; flags expiry once the count reaches MAX_WAIT.
module m_wait_timer #(
    parameter int unsigned MAX_WAIT = 16,
    parameter int unsigned WAIT_W   = 5
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_start,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_expired
);

    logic [WAIT_W-1:0] r_cnt;

    // Start loads 1: the cycle that issues the request is the first wait cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_start) begin
            r_cnt <= WAIT_W'(1);
        end else if (i_inc) begin
            r_cnt <= r_cnt + WAIT_W'(1);
        end
    end

    assign o_expired = (r_cnt == WAIT_W'(MAX_WAIT));

endmodule

// File: rtl/m_pipe_ctrl.sv
// Pipeline sequencer for the 4-slot RV32 core: stage enables, bubbles, flush,
// memory handshakes, debug halt/step, timeout fault and performance counters.
module m_pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W    = 32,
    parameter int unsigned MAX_WAIT = 16,
    parameter int unsigned WAIT_W   = 5
) (
    input  logic             w_clk,
    input  logic             w_rst,
    input  logic             w_imem_ack,
    input  logic             w_e_mem,
    input  logic             w_dmem_ack,
    input  logic             w_br_tkn,
    input  logic             w_halt_req,
    input  logic             w_step,
    output logic             w_pc_we,
    output logic             w_p1_we,
    output logic             w_p1_nop,
    output logic             w_p2_we,
    output logic             w_p2_nop,
    output logic             w_p3_we,
    output logic             w_dmem_req,
    output logic             w_halted,
    output logic             w_fault,
    output logic [CNT_W-1:0] w_cycle,
    output logic [CNT_W-1:0] w_instret,
    output logic [CNT_W-1:0] w_stall
);

    pipe_state_e      r_state, w_state_nxt;
    pipe_state_e      r_ret, w_ret_nxt;
    logic             r_v1, r_v2, r_v3;
    logic [CNT_W-1:0] r_cycle, r_instret, r_stall;
    logic             w_br, w_mem, w_live, w_adv;
    logic             w_t_start, w_t_inc, w_t_clr, w_t_expired;

    m_wait_timer #(
        .MAX_WAIT (MAX_WAIT),
        .WAIT_W   (WAIT_W)
    ) u_wait_timer (
        .i_clk     (w_clk),
        .i_rst     (w_rst),
        .i_start   (w_t_start),
        .i_inc     (w_t_inc),
        .i_clr     (w_t_clr),
        .o_expired (w_t_expired)
    );

    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            r_state <= StRun;
            r_ret   <= StRun;
        end else begin
            r_state <= w_state_nxt;
            r_ret   <= w_ret_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ret_nxt   = r_ret;
        w_t_start   = 1'b0;
        w_t_inc     = 1'b0;
        w_t_clr     = 1'b0;
        unique case (r_state)
            StRun: begin
                if (w_mem && !w_dmem_ack) begin
                    w_state_nxt = StMemWait;
                    w_ret_nxt   = StRun;
                    w_t_start   = 1'b1;
                end else if (w_halt_req) begin
                    w_state_nxt = StHalt;
                end
            end
            StMemWait: begin
                if (w_dmem_ack) begin
                    w_state_nxt = r_ret;
                    w_t_clr     = 1'b1;
                end else if (w_t_expired) begin
                    w_state_nxt = StFault;
                end else begin
                    w_t_inc = 1'b1;
                end
            end
            StHalt: begin
                // A step that stalls on dmem must come back to HALT, not RUN.
                if (w_step) begin
                    if (w_mem && !w_dmem_ack) begin
                        w_state_nxt = StMemWait;
                        w_ret_nxt   = StHalt;
                        w_t_start   = 1'b1;
                    end
                end else if (!w_halt_req) begin
                    w_state_nxt = StRun;
                end
            end
            StFault: w_state_nxt = StFault;
            default: w_state_nxt = StFault;
        endcase
    end

    always_comb begin
        w_br   = w_br_tkn & r_v2;
        w_mem  = r_v2 & w_e_mem;
        w_live = (r_state == StRun) || ((r_state == StHalt) && w_step);
        w_adv  = 1'b0;
        if (!w_rst) begin
            if (r_state == StMemWait) begin
                w_adv = w_dmem_ack;
            end else begin
                w_adv = w_live & (!w_mem | w_dmem_ack);
            end
        end
        w_dmem_req = !w_rst && w_mem && (w_live || (r_state == StMemWait));
        w_pc_we    = w_adv & (w_imem_ack | w_br);
        w_p1_we    = w_adv;
        w_p1_nop   = w_adv & (!w_imem_ack | w_br);
        w_p2_we    = w_adv;
        w_p2_nop   = w_adv & (!r_v1 | w_br);
        w_p3_we    = w_adv;
        w_halted   = (r_state == StHalt);
        w_fault    = (r_state == StFault);
    end

    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            r_v1      <= 1'b0;
            r_v2      <= 1'b0;
            r_v3      <= 1'b0;
            r_cycle   <= '0;
            r_instret <= '0;
            r_stall   <= '0;
        end else begin
            r_cycle <= r_cycle + CNT_W'(1);
            if (w_adv) begin
                r_v1 <= w_imem_ack & !w_br;
                r_v2 <= r_v1 & !w_br;
                r_v3 <= r_v2;
                if (r_v3) begin
                    r_instret <= r_instret + CNT_W'(1);
                end
            end
            if (((r_state == StRun) || (r_state == StMemWait)) && !w_adv) begin
                r_stall <= r_stall + CNT_W'(1);
            end
        end
    end

    assign w_cycle   = r_cycle;
    assign w_instret = r_instret;
    assign w_stall   = r_stall;

endmodule

// File: tb/tb_m_pipe_ctrl.sv
// Self-checking bench for m_pipe_ctrl: vector table, directed corner sequences
// and a randomized run against a slot-level pipeline model.
module tb_m_pipe_ctrl;

    localparam int MAX_WAIT = 4;
    localparam int M_RUN = 0, M_WAIT = 1, M_HALT = 2, M_FAULT = 3;

    logic        w_clk = 1'b0;
    logic        w_rst, w_imem_ack, w_e_mem, w_dmem_ack, w_br_tkn, w_halt_req, w_step;
    logic        w_pc_we, w_p1_we, w_p1_nop, w_p2_we, w_p2_nop, w_p3_we;
    logic        w_dmem_req, w_halted, w_fault;
    logic [31:0] w_cycle, w_instret, w_stall;

    m_pipe_ctrl #(
        .CNT_W    (32),
        .MAX_WAIT (MAX_WAIT),
        .WAIT_W   (3)
    ) dut (
        .w_clk      (w_clk),
        .w_rst      (w_rst),
        .w_imem_ack (w_imem_ack),
        .w_e_mem    (w_e_mem),
        .w_dmem_ack (w_dmem_ack),
        .w_br_tkn   (w_br_tkn),
        .w_halt_req (w_halt_req),
        .w_step     (w_step),
        .w_pc_we    (w_pc_we),
        .w_p1_we    (w_p1_we),
        .w_p1_nop   (w_p1_nop),
        .w_p2_we    (w_p2_we),
        .w_p2_nop   (w_p2_nop),
        .w_p3_we    (w_p3_we),
        .w_dmem_req (w_dmem_req),
        .w_halted   (w_halted),
        .w_fault    (w_fault),
        .w_cycle    (w_cycle),
        .w_instret  (w_instret),
        .w_stall    (w_stall)
    );

    always #5 w_clk = ~w_clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: each slot holds an instruction id (0 = bubble) for D, E, W.
    int          slot[3];
    int          next_id;
    int          m_mode, m_ret, m_wait;
    bit          m_known = 1'b0;
    logic [31:0] m_cyc, m_inst, m_stl;
    bit          e_adv, e_mem, e_br;
    logic [8:0]  e_ctl;

    logic [8:0]  s_ctl;
    logic [31:0] s_cycle, s_instret, s_stall;

    typedef struct {
        logic [6:0] in;
        logic [8:0] ctl;
    } vec_t;
    vec_t tbl[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_eval();
        bit live, ia, da;
        ia    = w_imem_ack;
        da    = w_dmem_ack;
        e_br  = w_br_tkn && (slot[1] != 0);
        e_mem = w_e_mem && (slot[1] != 0);
        live  = (m_mode == M_RUN) || (m_mode == M_HALT && w_step);
        if (w_rst) e_adv = 1'b0;
        else if (m_mode == M_WAIT) e_adv = da;
        else e_adv = live && !(e_mem && !da);
        e_ctl = {e_adv && (ia || e_br), e_adv, e_adv && (!ia || e_br), e_adv,
                 e_adv && (slot[0] == 0 || e_br), e_adv,
                 !w_rst && e_mem && (live || m_mode == M_WAIT),
                 m_mode == M_HALT, m_mode == M_FAULT};
    endtask

    task automatic model_update(input logic [6:0] v);
        bit rs, ia, da, hr, st;
        {rs, ia, da, hr, st} = {v[6], v[5], v[3], v[1], v[0]};
        if (rs) begin
            m_mode = M_RUN; m_ret = M_RUN; m_wait = 0;
            slot = '{0, 0, 0};
            m_cyc = 0; m_inst = 0; m_stl = 0; m_known = 1'b1;
            return;
        end
        m_cyc = m_cyc + 1;
        if ((m_mode == M_RUN || m_mode == M_WAIT) && !e_adv) m_stl = m_stl + 1;
        if (e_adv) begin
            if (slot[2] != 0) m_inst = m_inst + 1;
            slot[2] = slot[1];
            slot[1] = e_br ? 0 : slot[0];
            if (ia && !e_br) begin
                next_id++;
                slot[0] = next_id;
            end else begin
                slot[0] = 0;
            end
        end
        case (m_mode)
            M_RUN: begin
                if (e_mem && !da) begin
                    m_mode = M_WAIT; m_ret = M_RUN; m_wait = 1;
                end else if (hr) m_mode = M_HALT;
            end
            M_WAIT: begin
                if (da) begin
                    m_mode = m_ret; m_wait = 0;
                end else if (m_wait == MAX_WAIT) m_mode = M_FAULT;
                else m_wait++;
            end
            M_HALT: begin
                if (st) begin
                    if (e_mem && !da) begin
                        m_mode = M_WAIT; m_ret = M_HALT; m_wait = 1;
                    end
                end else if (!hr) m_mode = M_RUN;
            end
            default: m_mode = M_FAULT;
        endcase
    endtask

    // One clock: drive {rst, imem_ack, e_mem, dmem_ack, br_tkn, halt_req, step}.
    task automatic cyc(input logic [6:0] v, input string tag);
        {w_rst, w_imem_ack, w_e_mem, w_dmem_ack, w_br_tkn, w_halt_req, w_step} = v;
        #2;
        model_eval();
        s_ctl     = {w_pc_we, w_p1_we, w_p1_nop, w_p2_we, w_p2_nop, w_p3_we,
                     w_dmem_req, w_halted, w_fault};
        s_cycle   = w_cycle;
        s_instret = w_instret;
        s_stall   = w_stall;
        if (!m_known) begin
            chk({tag, "_ctl_rst"}, 32'(s_ctl[8:2]), 32'(e_ctl[8:2]));
        end else begin
            chk({tag, "_ctl"}, 32'(s_ctl), 32'(e_ctl));
            chk({tag, "_cycle"}, s_cycle, m_cyc);
            chk({tag, "_instret"}, s_instret, m_inst);
            chk({tag, "_stall"}, s_stall, m_stl);
        end
        @(posedge w_clk);
        model_update(v);
        #1;
    endtask

    initial begin
        tbl[0] = '{7'b1100000, 9'b000000000};
        tbl[1] = '{7'b0100000, 9'b110111000};
        tbl[2] = '{7'b0100000, 9'b110101000};
        tbl[3] = '{7'b0100000, 9'b110101000};
        tbl[4] = '{7'b0000000, 9'b011101000};
        tbl[5] = '{7'b0100100, 9'b111111000};
        tbl[6] = '{7'b0100100, 9'b110111000};
        tbl[7] = '{7'b0110000, 9'b110101000};
        tbl[8] = '{7'b0110000, 9'b000000100};
        tbl[9] = '{7'b0111000, 9'b110101100};
        next_id = 0;
        slot = '{0, 0, 0};
        {m_mode, m_ret, m_wait} = {M_RUN, M_RUN, 0};
        {m_cyc, m_inst, m_stl} = '0;
        {w_rst, w_imem_ack, w_e_mem, w_dmem_ack, w_br_tkn, w_halt_req, w_step} = 7'b1000000;
        @(posedge w_clk);
        #1;
        cyc(7'b1100000, "por");
        cyc(7'b1100000, "por");

        for (int i = 0; i < 10; i++) begin
            cyc(tbl[i].in, "tbl");
            chk($sformatf("tbl%0d_vec", i), 32'(s_ctl), 32'(tbl[i].ctl));
        end

        // Straight-line fetch: instret = N-3 after N cycles.
        cyc(7'b1100000, "t1");
        for (int i = 0; i < 10; i++) cyc(7'b0100000, "t1");
        cyc(7'b0100000, "t1");
        chk("t1_cycle10", s_cycle, 32'd10);
        chk("t1_instret7", s_instret, 32'd7);
        chk("t1_stall0", s_stall, 32'd0);

        // dmem ack on the fourth cycle of the access.
        cyc(7'b1100000, "t3");
        cyc(7'b0100000, "t3");
        cyc(7'b0100000, "t3");
        for (int i = 0; i < 3; i++) begin
            cyc(7'b0110000, "t3");
            chk("t3_frozen", 32'(s_ctl[8:2]), 32'b0000001);
        end
        cyc(7'b0111000, "t3");
        chk("t3_stall3", s_stall, 32'd3);
        chk("t3_ack_adv", 32'(s_ctl[7]), 32'd1);

        // No ack: fault after MAX_WAIT timer cycles, sticky until reset.
        cyc(7'b1100000, "t4");
        cyc(7'b0100000, "t4");
        cyc(7'b0100000, "t4");
        for (int i = 0; i < 5; i++) cyc(7'b0110000, "t4");
        cyc(7'b0110000, "t4");
        chk("t4_fault", 32'(s_ctl[0]), 32'd1);
        cyc(7'b0111000, "t4");
        chk("t4_fault_sticky", 32'(s_ctl[0]), 32'd1);
        cyc(7'b1100000, "t4");
        cyc(7'b0100000, "t4");
        chk("t4_fault_clear", 32'(s_ctl[1:0]), 32'd0);

        // Halt, then a single step, then a step that stalls on dmem.
        cyc(7'b1100000, "t5");
        for (int i = 0; i < 4; i++) cyc(7'b0100000, "t5");
        cyc(7'b0100010, "t5");
        for (int i = 0; i < 3; i++) begin
            cyc(7'b0100010, "t5");
            chk("t5_halted_frozen", 32'(s_ctl), 32'b000000010);
        end
        cyc(7'b0100011, "t5");
        cyc(7'b0100010, "t5");
        chk("t5_one_retire", s_instret, 32'd3);
        cyc(7'b0110011, "t6");
        cyc(7'b0110010, "t6");
        chk("t6_memwait", 32'(s_ctl[1]), 32'd0);
        cyc(7'b0111010, "t6");
        cyc(7'b0100010, "t6");
        chk("t6_back_halt", 32'(s_ctl[1]), 32'd1);
        cyc(7'b0100000, "t6");
        cyc(7'b0100000, "t6");
        chk("t6_resume", 32'(s_ctl[8]), 32'd1);

        // Randomized traffic.
        begin
            logic hr;
            int   dprob;
            hr = 1'b0;
            dprob = 6;
            for (int i = 0; i < 1500; i++) begin
                logic [6:0] v;
                if ($urandom_range(0, 19) == 0) hr = ~hr;
                if (i % 250 == 0) dprob = $urandom_range(0, 7);
                v[6] = ($urandom_range(0, 149) == 0);
                v[5] = ($urandom_range(0, 3) != 0);
                v[4] = ($urandom_range(0, 2) == 0);
                v[3] = ($urandom_range(0, 7) < dprob);
                v[2] = ($urandom_range(0, 3) == 0);
                v[1] = hr;
                v[0] = ($urandom_range(0, 4) == 0);
                cyc(v, "rnd");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
